task_10_input: RTL and testbench

Upstream companion of the task 10 output stage. Receives one request packet per transaction from the task manager as a byte stream, buffers it completely in an internal FIFO (store-and-forward), then streams it byte-by-byte to the task 10 core. While a packet is in flight it holds off the manager, and an optional length check discards malformed packets. Bytes reach the core only when the core reports ready; the core's ready is derived from the output stage's busy/full status.

---
 rtl/task_10_input_if.sv | 22 ++
 rtl/task_10_input.sv | 187 ++++++++++++++++++
 tb/tb_task_10_input.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/task_10_input_if.sv
// Handshake bundle between the task manager, task_10_input and the task 10 core.
// The master view is the traffic source/sink side (manager and core);
// the slave view is the task_10_input block itself.
interface task_10_input_if;
    logic       tmanager_valid;
    logic [7:0] tmanager_data;
    logic       tmanager_last;
    logic       tinput_ready;
    logic       core_ready;
    logic [7:0] data;
    logic       data_valid;

    modport master (
        output tmanager_valid, tmanager_data, tmanager_last, core_ready,
        input  tinput_ready, data, data_valid
    );

    modport slave (
        input  tmanager_valid, tmanager_data, tmanager_last, core_ready,
        output tinput_ready, data, data_valid
    );
endinterface

// File: rtl/task_10_input.sv
// task_10_input: store-and-forward packet buffer in front of the task 10 core.
// A whole packet is written into an internal FIFO, optionally length-checked,
// then streamed out one byte per cycle whenever the core is ready.
// Optional feature macro: TASK_10_INPUT_LEN_CHECK_EN (enables the length check,
// packet discard, o_pkt_err and o_err_count).
module task_10_input #(
    parameter int          DEPTH    = 64,
    parameter logic [11:0] PKT_SIZE = 12'd64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    task_10_input_if.slave           bus,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_pkt_err,
    output logic [7:0]               o_err_count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          LW      = AW + 1;
    localparam logic [11:0] DEPTH_C = 12'(DEPTH);

`ifdef TASK_10_INPUT_LEN_CHECK_EN
    localparam bit LEN_CHECK_EN = 1'b1;
`else
    localparam bit LEN_CHECK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_SKIP,
        S_CHECK,
        S_DISCARD,
        S_FORWARD
    } state_t;

    state_t         state_q;
    logic [11:0]    cnt_q;
    logic           ovf_q;
    logic           ready_q;
    logic           busy_q;
    logic [7:0]     data_q;
    logic           data_valid_q;
    logic           pkt_err_q;
    logic [7:0]     err_count_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [LW-1:0]  level_q;
    logic [LW-1:0]  level_d;
    logic [7:0]     mem [DEPTH];

    logic accept;
    logic wr_en;
    logic rd_en;
    logic len_bad;
    logic discard;

    // A manager byte transfers only while the registered ready is high.
    assign accept  = bus.tmanager_valid && ready_q;
    // Bytes are stored only before truncation; S_SKIP swallows the overflow tail.
    assign wr_en   = accept && ((state_q == S_IDLE) || (state_q == S_RECV));
    // The core is only consulted while forwarding.
    assign rd_en   = (state_q == S_FORWARD) && (level_q != '0) && bus.core_ready;
    assign len_bad = LEN_CHECK_EN && ((cnt_q != PKT_SIZE) || ovf_q);
    assign discard = (state_q == S_CHECK) && len_bad;
    assign level_d = level_q + LW'(wr_en) - LW'(rd_en);

    // Packet sequencing FSM with registered ready/busy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        cnt_q  <= 12'd1;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.tmanager_last) begin
                            state_q <= S_CHECK;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 12'd1;
                        if (bus.tmanager_last) begin
                            state_q <= S_CHECK;
                            ready_q <= 1'b0;
                        end else if ((cnt_q + 12'd1) == DEPTH_C) begin
                            state_q <= S_SKIP;
                            ovf_q   <= 1'b1;
                        end
                    end
                end
                S_SKIP: begin
                    if (accept && bus.tmanager_last) begin
                        state_q <= S_CHECK;
                        ready_q <= 1'b0;
                    end
                end
                S_CHECK: begin
                    state_q <= len_bad ? S_DISCARD : S_FORWARD;
                end
                S_DISCARD: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                S_FORWARD: begin
                    // The last read has already been issued once the FIFO reads empty.
                    if (level_q == '0) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a discarded packet is flushed in one go.
    always_ff @(posedge i_clk) begin
        if (i_rst || discard) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // FIFO storage write port (no reset so it maps onto block RAM).
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.tmanager_data;
    end

    // Registered read port; the strobe follows each read by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q       <= 8'd0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_en;
            if (rd_en) data_q <= mem[rd_ptr_q];
        end
    end

    // Discard reporting: one-cycle pulse and saturating counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkt_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            pkt_err_q <= discard;
            if (discard && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
        end
    end

    assign bus.tinput_ready = ready_q;
    assign bus.data         = data_q;
    assign bus.data_valid   = data_valid_q;
    assign o_busy           = busy_q;
    assign o_level          = level_q;
    assign o_pkt_err        = LEN_CHECK_EN & pkt_err_q;
    assign o_err_count      = LEN_CHECK_EN ? err_count_q : 8'd0;

endmodule

// File: tb/tb_task_10_input.sv
// Self-checking bench for task_10_input: directed scenarios plus randomized
// packets, checked against a packet-level model (expected byte queue and
// expected discard count).
module tb_task_10_input;

    localparam int DEPTH = 64;
    localparam int PKT   = 64;
`ifdef TASK_10_INPUT_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       o_busy;
    logic [6:0] o_level;
    logic       o_pkt_err;
    logic [7:0] o_err_count;

    task_10_input_if bus_if();

    task_10_input #(.DEPTH(DEPTH), .PKT_SIZE(12'(PKT))) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus_if),
        .o_busy     (o_busy),
        .o_level    (o_level),
        .o_pkt_err  (o_pkt_err),
        .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int         dv_cyc[$];
    int         exp_disc = 0;
    int         err_pulses = 0;
    int         last_cyc = 0;
    int         cr_mode = 0;
    logic [7:0] exp_byte;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Core-ready driver: 0 = always ready, 1 = toggle, 2 = random.
    initial begin
        bus_if.core_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (cr_mode)
                0: bus_if.core_ready = 1'b1;
                1: bus_if.core_ready = ~bus_if.core_ready;
                default: bus_if.core_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.data_valid) begin
                dv_cyc.push_back(ncyc);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_strobe", int'(bus_if.data), -1);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check_eq("data", int'(bus_if.data), int'(exp_byte));
                end
            end
            if (o_pkt_err) err_pulses++;
            if (exp_q.size() > 0) begin
                check_eq("ready_low_in_flight", int'(bus_if.tinput_ready), 0);
                check_eq("busy_in_flight", int'(o_busy), 1);
            end
            check_eq("level_bound", int'(o_level <= 7'(DEPTH)), 1);
        end
    end

    // Packet-level model: what leaves the block for a completed packet.
    task automatic model_push(input logic [7:0] pkt[$]);
        int  len;
        int  stored;
        bit  bad;
        len    = pkt.size();
        stored = (len > DEPTH) ? DEPTH : len;
        bad    = LEN_CHECK && ((len != PKT) || (len > DEPTH));
        if (bad) exp_disc++;
        else for (int j = 0; j < stored; j++) exp_q.push_back(pkt[j]);
    endtask

    // Send one packet; starts and ends just after a rising edge.
    task automatic send_packet(input int len, input bit rand_data, input int gap_pct, input bit partial);
        logic [7:0] pkt[$];
        int   i;
        int   guard;
        logic rdy;
        for (int j = 0; j < len; j++) pkt.push_back(rand_data ? 8'($urandom_range(255)) : 8'(j));
        i = 0;
        guard = 0;
        while (i < len && guard < 5000) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                bus_if.tmanager_valid = 1'b0;
                bus_if.tmanager_last  = 1'b0;
            end else begin
                bus_if.tmanager_valid = 1'b1;
                bus_if.tmanager_data  = pkt[i];
                bus_if.tmanager_last  = !partial && (i == len - 1);
            end
            @(negedge clk);
            rdy = bus_if.tinput_ready;
            if (bus_if.tmanager_valid && rdy && bus_if.tmanager_last) last_cyc = ncyc;
            @(posedge clk);
            #1;
            if (bus_if.tmanager_valid && rdy) i++;
            guard++;
        end
        bus_if.tmanager_valid = 1'b0;
        bus_if.tmanager_last  = 1'b0;
        check_eq("send_accepted", i, len);
        if (!partial && i == len) model_push(pkt);
    endtask

    // Hold 0xAA on the manager bus until the packet has been delivered.
    task automatic hold_junk();
        int n;
        bus_if.tmanager_valid = 1'b1;
        bus_if.tmanager_data  = 8'hAA;
        bus_if.tmanager_last  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (exp_q.size() != 0 && n < 2000);
        bus_if.tmanager_valid = 1'b0;
        check_eq("junk_timeout", int'(n >= 2000), 0);
        @(posedge clk);
        #1;
    endtask

    // Wait for the block to return to idle, then check packet-end state.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(bus_if.tinput_ready && !o_busy && exp_q.size() == 0) && n < 3000);
        check_eq($sformatf("%s_idle_timeout", name), int'(n >= 3000), 0);
        check_eq($sformatf("%s_level", name), int'(o_level), 0);
        check_eq($sformatf("%s_err_pulses", name), err_pulses, exp_disc);
        check_eq($sformatf("%s_err_count", name), int'(o_err_count), (exp_disc > 255) ? 255 : exp_disc);
        $display("pkt %s: strobes=%0d discards=%0d level=%0d", name, dv_cyc.size(), exp_disc, o_level);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string name);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_disc   = 0;
        err_pulses = 0;
        exp_q.delete();
        @(negedge clk);
        check_eq($sformatf("%s_ready", name), int'(bus_if.tinput_ready), 0);
        check_eq($sformatf("%s_busy", name), int'(o_busy), 0);
        check_eq($sformatf("%s_level", name), int'(o_level), 0);
        check_eq($sformatf("%s_dv", name), int'(bus_if.data_valid), 0);
        check_eq($sformatf("%s_data", name), int'(bus_if.data), 0);
        check_eq($sformatf("%s_pkt_err", name), int'(o_pkt_err), 0);
        check_eq($sformatf("%s_err_count", name), int'(o_err_count), 0);
        @(negedge clk);
        check_eq($sformatf("%s_ready_rise", name), int'(bus_if.tinput_ready), 1);
        @(posedge clk);
        #1;
    endtask

    int bad_gap;
    int len;

    initial begin
        rst = 1'b1;
        bus_if.tmanager_valid = 1'b0;
        bus_if.tmanager_data  = 8'h00;
        bus_if.tmanager_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        apply_reset("reset");

        // Nominal 64-byte packet 0x00..0x3F.
        dv_cyc.delete();
        send_packet(64, 1'b0, 0, 1'b0);
        wait_idle("nominal");
        check_eq("nominal_count", dv_cyc.size(), 64);
        if (dv_cyc.size() == 64) begin
            check_eq("nominal_latency", dv_cyc[0] - last_cyc, 3);
            check_eq("nominal_span", dv_cyc[63] - dv_cyc[0], 63);
        end

        // Core backpressure: ready toggles every cycle.
        cr_mode = 1;
        dv_cyc.delete();
        send_packet(64, 1'b0, 0, 1'b0);
        wait_idle("backpressure");
        cr_mode = 0;
        check_eq("bp_count", dv_cyc.size(), 64);
        bad_gap = 0;
        for (int k = 1; k < dv_cyc.size(); k++) if (dv_cyc[k] - dv_cyc[k-1] != 2) bad_gap++;
        check_eq("bp_spacing_bad", bad_gap, 0);

        // Short packet.
        dv_cyc.delete();
        send_packet(10, 1'b1, 0, 1'b0);
        wait_idle("short");
        check_eq("short_count", dv_cyc.size(), LEN_CHECK ? 0 : 10);
        check_eq("short_errcnt", int'(o_err_count), LEN_CHECK ? 1 : 0);

        // Overflow: 70 bytes into a 64-byte FIFO.
        dv_cyc.delete();
        send_packet(70, 1'b1, 0, 1'b0);
        wait_idle("overflow");
        check_eq("overflow_count", dv_cyc.size(), LEN_CHECK ? 0 : 64);
        check_eq("overflow_errcnt", int'(o_err_count), LEN_CHECK ? 2 : 0);

        // Reset in the middle of a packet, then a clean packet.
        dv_cyc.delete();
        send_packet(20, 1'b1, 0, 1'b1);
        check_eq("midpkt_level_before", int'(o_level), 20);
        apply_reset("midreset");
        check_eq("midreset_no_strobe", dv_cyc.size(), 0);
        send_packet(64, 1'b1, 0, 1'b0);
        wait_idle("after_reset");
        check_eq("after_reset_count", dv_cyc.size(), 64);

        // Manager keeps pushing 0xAA while the block is forwarding.
        dv_cyc.delete();
        send_packet(64, 1'b1, 0, 1'b0);
        hold_junk();
        wait_idle("ignored");
        check_eq("ignored_count", dv_cyc.size(), 64);

        // Randomized packets with gaps and random core readiness.
        cr_mode = 2;
        for (int p = 0; p < 10; p++) begin
            len = ($urandom_range(2) == 0) ? PKT : int'($urandom_range(1, 80));
            dv_cyc.delete();
            send_packet(len, 1'b1, 30, 1'b0);
            wait_idle($sformatf("rand%0d_len%0d", p, len));
        end
        cr_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
